// File: rtl/fb_pkg.sv
// Framebuffer capture types and geometry shared between the capture and scan-out blocks.
package fb_pkg;
  localparam int H_PIX    = 160;
  localparam int V_LINES  = 144;
  localparam int FB_WORDS = H_PIX * V_LINES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HOLD,
    ST_SKIP
  } cap_state_e;
endpackage

// File: rtl/fb_capture_ctrl_sync_filter.sv
// 2-FF synchroniser plus FILT-sample deglitch filter with registered level and edge strobes.
module sync_filter #(
  parameter int FILT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic          s1_q, s2_q, lvl_q, rise_q, fall_q;
  logic [CW-1:0] cnt_q;
  logic          flip;

  // Level flips once FILT consecutive synchronised samples disagree with it.
  assign flip = (s2_q != lvl_q) && (cnt_q == CW'(FILT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      if (s2_q == lvl_q || flip) cnt_q <= '0;
      else                       cnt_q <= cnt_q + 1'b1;
      if (flip) lvl_q <= s2_q;
      rise_q <= flip &  s2_q;
      fall_q <= flip & ~s2_q;
    end
  end

  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/fb_capture_ctrl.sv
// Game Boy LCD capture sequencer: filtered sync decode, linear addressing and vblank-safe bank swap.
module fb_capture_ctrl import fb_pkg::*; #(
  parameter int H_PIX   = fb_pkg::H_PIX,
  parameter int V_LINES = fb_pkg::V_LINES,
  parameter int ADDR_W  = 15,
  parameter int FILT    = 3,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iclk,
  input  logic              ihsync,
  input  logic              ivsync,
  input  logic [1:0]        idata,
  input  logic              scan_vblank,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [1:0]        wr_data,
  output logic              rd_bank,
  output logic              frame_done,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  short_cnt
);
  localparam int XW = $clog2(H_PIX + 1);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0]     X_END  = XW'(H_PIX);
  localparam logic [XW-1:0]     X_LAST = XW'(H_PIX - 1);
  localparam logic [YW-1:0]     Y_END  = YW'(V_LINES);
  localparam logic [YW-1:0]     Y_LAST = YW'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIX);

  logic pix_stb, hs_rise, vs_rise;
  logic pclk_lvl, pclk_rise, hs_lvl, hs_fall, vs_lvl, vs_fall;
  logic unused_edges;

  sync_filter #(.FILT(FILT)) u_pclk (.clk(clk), .rst_n(rst_n), .d(iclk),
    .level(pclk_lvl), .rise(pclk_rise), .fall(pix_stb));
  sync_filter #(.FILT(FILT)) u_hs (.clk(clk), .rst_n(rst_n), .d(ihsync),
    .level(hs_lvl), .rise(hs_rise), .fall(hs_fall));
  sync_filter #(.FILT(FILT)) u_vs (.clk(clk), .rst_n(rst_n), .d(ivsync),
    .level(vs_lvl), .rise(vs_rise), .fall(vs_fall));

  assign unused_edges = ^{pclk_lvl, pclk_rise, hs_lvl, hs_fall, vs_lvl, vs_fall};

  // Data rides a plain 2-FF sync; at strobe time it reflects the pin well inside the iclk low phase.
  logic [1:0] d_s1_q, d_s2_q;

  cap_state_e        state_q, state_d;
  logic [XW-1:0]     x_q, x_d, x_cur;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] lb_q, lb_d;
  logic              fl_q, fl_d;
  logic              pend_q, pend_d, wbank_q, rd_bank_q;
  logic              wr_go, last_px, set_pend, swap, drop_inc, short_inc;
  logic              wr_en_q, fd_q;
  logic [ADDR_W:0]   wr_addr_q;
  logic [1:0]        wr_data_q;
  logic [CNT_W-1:0]  drop_q, short_q;

  // vsync outranks everything; hsync is applied before a coincident pixel lands.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    lb_d  = lb_q;
    fl_d  = fl_q;
    x_cur = hs_rise ? '0 : x_q;
    if (vs_rise) begin
      x_d  = '0;
      y_d  = '0;
      lb_d = '0;
      fl_d = 1'b1;
    end else begin
      if (hs_rise) begin
        x_d = '0;
        if (fl_q) fl_d = 1'b0;
        else if (y_q < Y_END) begin
          y_d  = y_q + YW'(1);
          lb_d = lb_q + H_STEP;
        end
      end
      if (pix_stb && x_cur < X_END) x_d = x_cur + XW'(1);
    end
    wr_go   = pix_stb && !vs_rise && (state_q == ST_CAPTURE) && (x_cur < X_END) && (y_d < Y_END);
    last_px = wr_go && (x_cur == X_LAST) && (y_d == Y_LAST);
  end

  always_comb begin
    state_d   = state_q;
    set_pend  = 1'b0;
    drop_inc  = 1'b0;
    short_inc = 1'b0;
    case (state_q)
      ST_IDLE:
        if (vs_rise) state_d = pend_q ? ST_SKIP : ST_CAPTURE;
      ST_CAPTURE:
        if (vs_rise) begin
          short_inc = 1'b1;
          state_d   = pend_q ? ST_SKIP : ST_CAPTURE;
        end else if (last_px) begin
          state_d  = ST_HOLD;
          set_pend = 1'b1;
        end
      ST_HOLD, ST_SKIP:
        if (vs_rise) begin
          if (pend_q) begin
            state_d  = ST_SKIP;
            drop_inc = 1'b1;
          end else begin
            state_d  = ST_CAPTURE;
          end
        end
      default: state_d = ST_IDLE;
    endcase
    // pend_q (not pend_d) gates the swap, so a coincident vblank waits for the next one.
    swap   = scan_vblank && pend_q && (state_q != ST_CAPTURE);
    pend_d = set_pend ? 1'b1 : (swap ? 1'b0 : pend_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1_q    <= '0;
      d_s2_q    <= '0;
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      lb_q      <= '0;
      fl_q      <= 1'b0;
      pend_q    <= 1'b0;
      wbank_q   <= 1'b1;
      rd_bank_q <= 1'b0;
      wr_en_q   <= 1'b0;
      fd_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      drop_q    <= '0;
      short_q   <= '0;
    end else begin
      d_s1_q  <= idata;
      d_s2_q  <= d_s1_q;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lb_q    <= lb_d;
      fl_q    <= fl_d;
      pend_q  <= pend_d;
      if (swap) begin
        rd_bank_q <= wbank_q;
        wbank_q   <= ~wbank_q;
      end
      wr_en_q <= wr_go;
      fd_q    <= last_px;
      if (wr_go) begin
        wr_addr_q <= {wbank_q, lb_d + ADDR_W'(x_cur)};
        wr_data_q <= d_s2_q;
      end
      if (drop_inc  && drop_q  != '1) drop_q  <= drop_q  + 1'b1;
      if (short_inc && short_q != '1) short_q <= short_q + 1'b1;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_bank    = rd_bank_q;
  assign frame_done = fd_q;
  assign drop_cnt   = drop_q;
  assign short_cnt  = short_q;
endmodule

// File: tb/tb_fb_capture_ctrl.sv
// Scoreboard bench for fb_capture_ctrl on a reduced 8x4 frame so full-frame cases stay short.
module tb_fb_capture_ctrl;
  localparam int H = 8, V = 4, AW = 15, FILT = 3, CW = 2;

  logic clk = 0, rst_n = 0, iclk = 1, ihsync = 0, ivsync = 0, scan_vblank = 0;
  logic [1:0]    idata = 0;
  logic          wr_en, rd_bank, frame_done;
  logic [AW:0]   wr_addr;
  logic [1:0]    wr_data;
  logic [CW-1:0] drop_cnt, short_cnt;

  fb_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW), .FILT(FILT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .iclk(iclk), .ihsync(ihsync), .ivsync(ivsync), .idata(idata),
    .scan_vblank(scan_vblank), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_bank(rd_bank), .frame_done(frame_done), .drop_cnt(drop_cnt), .short_cnt(short_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW:0] addr;
    logic [1:0]  data;
    logic        fd;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0, n_bad = 0, fd_cnt = 0;

  // Monitor: every write strobe is matched against the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (wr_en) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_write: got addr %0h data %0d, required no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data, frame_done} !== e) begin
            n_bad++;
            $display("FAIL write: got addr %0h data %0d fd %0b, required addr %0h data %0d fd %0b",
                     wr_addr, wr_data, frame_done, e.addr, e.data, e.fd);
          end
        end
      end else if (frame_done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_frame_done: got frame_done without wr_en, required none");
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input logic [1:0] d, input bit exp, input logic [AW:0] a, input bit fd);
    if (exp) exp_q.push_back('{addr: a, data: d, fd: fd});
    @(negedge clk); iclk = 0; idata = d;
    tick(4); iclk = 1;
    tick(4);
  endtask

  task automatic hsync();
    @(negedge clk); ihsync = 1; tick(4); ihsync = 0; tick(4);
  endtask

  task automatic vsync();
    @(negedge clk); ivsync = 1; tick(4); ivsync = 0; tick(4);
  endtask

  task automatic vblank();
    @(negedge clk); scan_vblank = 1;
    @(negedge clk); scan_vblank = 0;
  endtask

  task automatic line(input bit bnk, input int y, input int npix, input bit exp);
    hsync();
    for (int x = 0; x < npix; x++)
      pix(2'((x + y) & 3), exp && (x < H), {bnk, AW'(y * H + x)}, (x == H - 1) && (y == V - 1));
  endtask

  task automatic frame(input bit bnk, input int npix0, input bit exp);
    vsync();
    for (int y = 0; y < V; y++) line(bnk, y, (y == 0) ? npix0 : H, exp);
  endtask

  // Simultaneous hsync (or vsync) and pixel edges reach the filters on the same cycle.
  task automatic sync_pix(input bit use_vs, input logic [1:0] d, input bit exp, input logic [AW:0] a);
    if (exp) exp_q.push_back('{addr: a, data: d, fd: 1'b0});
    @(negedge clk);
    if (use_vs) ivsync = 1; else ihsync = 1;
    iclk = 0; idata = d;
    tick(4); ivsync = 0; ihsync = 0; iclk = 1;
    tick(4);
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin tick(1); i++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d writes outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_wr_en"},      32'(wr_en),      0);
    chk({nm, "_wr_addr"},    32'(wr_addr),    0);
    chk({nm, "_wr_data"},    32'(wr_data),    0);
    chk({nm, "_rd_bank"},    32'(rd_bank),    0);
    chk({nm, "_frame_done"}, 32'(frame_done), 0);
    chk({nm, "_drop_cnt"},   32'(drop_cnt),   0);
    chk({nm, "_short_cnt"},  32'(short_cnt),  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk_reset("reset");
    rst_n = 1;
    tick(12);

    // Full frame into bank 1.
    frame(1'b1, H, 1'b1);
    drain("t1_drain");
    chk("t1_frame_done_cnt", fd_cnt, 1);
    chk("t1_rd_bank", 32'(rd_bank), 0);

    // Swap, then the next frame lands in bank 0.
    vblank();
    chk("t2_rd_bank_after_swap", 32'(rd_bank), 1);
    frame(1'b0, H, 1'b1);
    drain("t2_drain");
    chk("t2_frame_done_cnt", fd_cnt, 2);
    vblank();
    chk("t2_rd_bank_back", 32'(rd_bank), 0);

    // Glitches on iclk are rejected; a full-width low writes once.
    vsync();
    line(1'b1, 0, 0, 1'b0);
    @(negedge clk); iclk = 0; @(negedge clk); iclk = 1; tick(8);
    @(negedge clk); iclk = 0; tick(2);         iclk = 1; tick(8);
    pix(2'd3, 1'b1, 16'h8000, 1'b0);
    drain("t3_single_write");
    line(1'b1, 1, H, 1'b1);
    drain("t5_line1");

    // Early vsync aborts the frame; pending stays clear so vblank does nothing.
    vsync();
    chk("t5_short_cnt", 32'(short_cnt), 1);
    vblank();
    chk("t5_rd_bank_no_swap", 32'(rd_bank), 0);
    for (int y = 0; y < V; y++) line(1'b1, y, H, 1'b1);
    drain("t5_restart_frame");
    chk("t5_frame_done_cnt", fd_cnt, 3);

    // Overlong first line: extra strobes dropped, line 1 still starts at 8.
    vblank();
    chk("t6_rd_bank_swap", 32'(rd_bank), 1);
    frame(1'b0, H + 3, 1'b1);
    drain("t6_overlong");

    // No vblank since the last frame: following frames are skipped and counted.
    frame(1'b0, H, 1'b0);
    drain("t4_skip_drain");
    chk("t4_drop_cnt", 32'(drop_cnt), 1);
    chk("t4_rd_bank_same", 32'(rd_bank), 1);
    vsync(); vsync(); vsync();
    chk("t4_drop_saturate", 32'(drop_cnt), 3);

    // Swap releases SKIP; repeated early vsyncs saturate short_cnt.
    vblank();
    chk("sat_rd_bank", 32'(rd_bank), 0);
    repeat (5) vsync();
    chk("short_saturate", 32'(short_cnt), 3);
    chk("drop_held", 32'(drop_cnt), 3);

    // hsync with a pixel: pixel goes to x=0; vsync with a pixel: pixel dropped.
    sync_pix(1'b0, 2'd2, 1'b1, 16'h8000);
    sync_pix(1'b0, 2'd1, 1'b1, 16'h8008);
    sync_pix(1'b1, 2'd3, 1'b0, 16'h0000);
    sync_pix(1'b0, 2'd3, 1'b1, 16'h8000);
    drain("coincident_edges");

    // Reset during an in-flight pixel: everything returns to reset values.
    @(negedge clk); iclk = 0; idata = 2'd1;
    tick(3);
    rst_n = 0;
    #1;
    chk_reset("midreset");
    tick(3);
    iclk = 1;
    @(negedge clk); rst_n = 1;
    tick(20);
    chk_reset("post_reset");
    chk("post_reset_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
